dct_frame_sequencer: RTL

Streaming front/back end for the DCT datapath. Packs a valid/ready stream of floating-point samples into ping-pong frame banks and hands each full frame to the DCT kernel with a start/done handshake. Captures the kernel result and serialises it onto an output valid/ready stream. Generalises the fixed-length, free-running engine shell with:
- runtime frame length
- double buffering
- backpressure on both sides
- kernel timeout detection

---
 rtl/dct_frame_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dct_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dct_frame_sequencer
// Purpose  : Streaming front/back end for the DCT datapath. Packs a
//            valid/ready sample stream into two ping-pong frame banks,
//            issues each full frame to the DCT kernel with a start/done
//            handshake, captures the kernel result and serialises it onto
//            an output valid/ready stream. The kernel run is bounded by a
//            timeout that raises a sticky error flag.
// Ports    : clk, reset (sync, active-low)
//            en                       - gates frame acceptance and kernel start
//            cfg_npts                 - requested frame length (0/oversize -> MAX_POINT)
//            in_valid/in_ready/in_data - input sample stream
//            kern_start/kern_npts/kern_frame - kernel issue interface
//            kern_done/kern_result    - kernel completion interface
//            out_valid/out_ready/out_data/out_last - output sample stream
//            busy, err_timeout        - status
// Revision : 1.0 - initial release
// ============================================================================
module dct_frame_sequencer #(
    parameter int MAX_POINT = 16,
    parameter int M         = 23,
    parameter int E         = 8,
    parameter int PW        = $clog2(MAX_POINT) + 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [PW-1:0]                  cfg_npts,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [M+E:0]                   in_data,
    output logic                           kern_start,
    output logic [PW-1:0]                  kern_npts,
    output logic [(M+E+1)*MAX_POINT-1:0]   kern_frame,
    input  logic                           kern_done,
    input  logic [(M+E+1)*MAX_POINT-1:0]   kern_result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [M+E:0]                   out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int W  = M + E + 1;
    localparam int IW = (MAX_POINT > 1) ? $clog2(MAX_POINT) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] c_max_npts = PW'(MAX_POINT);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  r_bank      [2][MAX_POINT];
    logic [PW-1:0] r_bank_npts [2];
    logic [1:0]    r_full;
    logic          r_wr_sel;
    logic [PW-1:0] r_wr_cnt;
    logic          r_rd_sel;
    state_t        r_state;
    logic          r_kern_start;
    logic [TW-1:0] r_timer;
    logic [W-1:0]  r_out_bank  [MAX_POINT];
    logic          r_out_full;
    logic [PW-1:0] r_out_npts;
    logic [PW-1:0] r_rd_idx;
    logic          r_err;
    // Holds in_ready low until the first clock edge after reset release.
    logic          r_live;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [PW-1:0] w_cfg_npts;
    logic [PW-1:0] w_fill_npts;
    logic [PW-1:0] w_run_npts;
    logic          w_in_fire;
    logic          w_fill_last;
    logic          w_out_fire;
    logic          w_out_last;
    logic          w_out_free;
    logic          w_run;

    assign w_cfg_npts  = ((cfg_npts == '0) || (cfg_npts > c_max_npts)) ? c_max_npts : cfg_npts;
    assign in_ready    = r_live && en && !r_full[r_wr_sel];
    assign w_in_fire   = in_valid && in_ready;
    // The frame length is taken from cfg_npts only on the first beat; later
    // beats use the value latched for the bank being filled.
    assign w_fill_npts = (r_wr_cnt == '0) ? w_cfg_npts : r_bank_npts[r_wr_sel];
    assign w_fill_last = (r_wr_cnt == (w_fill_npts - 1'b1));

    assign w_out_fire  = r_out_full && out_ready;
    assign w_out_last  = r_out_full && (r_rd_idx == (r_out_npts - 1'b1));
    // Output bank counts as free in the cycle its last beat is accepted, so
    // the next kernel start can follow immediately.
    assign w_out_free  = !r_out_full || (w_out_fire && w_out_last);

    assign w_run       = (r_state == ST_RUN);
    assign w_run_npts  = r_bank_npts[r_rd_sel];

    assign kern_start  = r_kern_start;
    assign kern_npts   = w_run ? w_run_npts : '0;

    // Lanes beyond the frame length are masked so stale samples from a
    // longer earlier frame never reach the kernel.
    for (genvar gi = 0; gi < MAX_POINT; gi++) begin : g_lane
        assign kern_frame[gi*W +: W] = (w_run && (PW'(gi) < w_run_npts)) ?
                                       r_bank[r_rd_sel][gi] : '0;
    end

    assign out_valid   = r_out_full;
    assign out_data    = r_out_bank[r_rd_idx[IW-1:0]];
    assign out_last    = w_out_last;
    assign busy        = r_full[0] || r_full[1] || w_run;
    assign err_timeout = r_err;

    // ------------------------------------------------------------------
    // Fill side, kernel FSM and output side share the bank-full flags, so
    // they live in one sequential block.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MAX_POINT; i++) begin
                    r_bank[b][i] <= '0;
                end
                r_bank_npts[b] <= '0;
            end
            for (int i = 0; i < MAX_POINT; i++) begin
                r_out_bank[i] <= '0;
            end
            r_full       <= '0;
            r_wr_sel     <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_sel     <= 1'b0;
            r_state      <= ST_IDLE;
            r_kern_start <= 1'b0;
            r_timer      <= '0;
            r_out_full   <= 1'b0;
            r_out_npts   <= '0;
            r_rd_idx     <= '0;
            r_err        <= 1'b0;
            r_live       <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_kern_start <= 1'b0;

            // Fill side
            if (w_in_fire) begin
                r_bank[r_wr_sel][r_wr_cnt[IW-1:0]] <= in_data;
                if (r_wr_cnt == '0) begin
                    r_bank_npts[r_wr_sel] <= w_cfg_npts;
                end
                if (w_fill_last) begin
                    r_wr_cnt <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            // Output drain
            if (w_out_fire) begin
                if (w_out_last) begin
                    r_out_full <= 1'b0;
                    r_rd_idx   <= '0;
                end else begin
                    r_rd_idx   <= r_rd_idx + 1'b1;
                end
            end

            // Kernel FSM
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rd_sel] && w_out_free && en) begin
                        r_state      <= ST_RUN;
                        r_kern_start <= 1'b1;
                        r_timer      <= '0;
                    end
                end
                ST_RUN: begin
                    if (kern_done) begin
                        for (int i = 0; i < MAX_POINT; i++) begin
                            r_out_bank[i] <= (i < int'(w_run_npts)) ? kern_result[i*W +: W] : '0;
                        end
                        r_out_full       <= 1'b1;
                        r_out_npts       <= w_run_npts;
                        r_full[r_rd_sel] <= 1'b0;
                        r_rd_sel         <= ~r_rd_sel;
                        r_state          <= ST_IDLE;
                    end else if (r_timer == c_tmo_last) begin
                        r_err            <= 1'b1;
                        r_full[r_rd_sel] <= 1'b0;
                        r_rd_sel         <= ~r_rd_sel;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A bank completing fill is never the bank being released above
            // (a full bank cannot accept input), so ordering here is benign.
            if (w_in_fire && w_fill_last) begin
                r_full[r_wr_sel] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
